// File: rtl/ddr4_app_pkg.sv
// Shared definitions for the DDR4 app-interface responder.
// Holds the app command encodings, the execution state encoding and the
// default interface widths used by ddr4_app_responder and its FIFOs.
package ddr4_app_pkg;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 512;
  localparam int MASK_W = 64;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_WR      = 2'd2,
    ST_RD      = 2'd3
  } exec_st_e;

endpackage

// File: rtl/ddr4_app_sfifo.sv
// Single-clock FIFO with full/empty flags and occupancy count.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, wdata_i     write side; a push on a full FIFO is taken only
//                       when a pop happens in the same cycle
//   pop_i, rdata_o      read side; rdata_o shows the head (show-ahead)
//   full_o, empty_o     flags from occupancy at the start of the cycle
//   count_o             occupancy
module ddr4_app_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import ddr4_app_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ddr4_app_responder.sv
// Memory-side responder for the DDR4 controller app interface (ui_clk domain).
// Queues app commands and write data, executes them in order against an
// on-chip burst array, and returns read data a fixed RD_LAT cycles after
// each read executes. Used in place of the real controller for loopback.
// Ports: ui_clk/ui_clk_sync_rst (sync, active-high); app_en/app_cmd/
//   app_addr/app_rdy command channel; app_wdf_* write-data channel;
//   app_rd_data/_valid/_end read return; init_calib_complete; sticky
//   cmd_err (illegal command, wren without end) and ovf_err (wdf full with
//   no queued write to drain it).
// Build option: define DDR4_RESP_THROTTLE_EN to have an LFSR randomly
//   withhold app_rdy / app_wdf_rdy (each ~25% of cycles).
//
// Execution state, decided each cycle from the command FIFO head:
//   state      | meaning
//   ST_IDLE    | command FIFO empty
//   ST_WR_WAIT | head is a write, its data not yet in the wdf FIFO
//   ST_WR      | merging wdf head into mem, popping both FIFOs
//   ST_RD      | reading mem into the latency pipe, popping the command
module ddr4_app_responder #(
  parameter int ADDR_W       = ddr4_app_pkg::ADDR_W,
  parameter int DATA_W       = ddr4_app_pkg::DATA_W,
  parameter int MASK_W       = ddr4_app_pkg::MASK_W,
  parameter int MEM_AW       = 10,
  parameter int CMD_DEPTH    = 8,
  parameter int WDF_DEPTH    = 16,
  parameter int RD_LAT       = 4,
  parameter int CALIB_CYCLES = 64
) (
  input  logic              ui_clk,
  input  logic              ui_clk_sync_rst,
  input  logic              app_en,
  input  logic [2:0]        app_cmd,
  input  logic [ADDR_W-1:0] app_addr,
  output logic              app_rdy,
  input  logic              app_wdf_wren,
  input  logic              app_wdf_end,
  input  logic [DATA_W-1:0] app_wdf_data,
  input  logic [MASK_W-1:0] app_wdf_mask,
  output logic              app_wdf_rdy,
  output logic [DATA_W-1:0] app_rd_data,
  output logic              app_rd_data_valid,
  output logic              app_rd_data_end,
  output logic              init_calib_complete,
  output logic              cmd_err,
  output logic              ovf_err
);
  import ddr4_app_pkg::*;

  localparam int CAW   = $clog2(CMD_DEPTH);
  localparam int WAW   = $clog2(WDF_DEPTH);
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int CMD_W = 3 + MEM_AW;
  localparam int WDF_W = DATA_W + MASK_W;

  logic              rst;
  logic [CW-1:0]     cal_cnt_q;
  logic              calib;
  logic              thr_cmd, thr_wdf;

  logic              cmd_full, cmd_empty, wdf_full, wdf_empty;
  logic [CAW:0]      cmd_cnt, rd_cnt_q;
  logic [WAW:0]      wdf_cnt;
  logic [CMD_W-1:0]  cmd_head;
  logic [WDF_W-1:0]  wdf_head;
  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;
  logic [DATA_W-1:0] head_data;
  logic [MASK_W-1:0] head_mask;

  logic              cmd_acc, cmd_legal, cmd_push, wdf_push;
  logic              cmd_pop, wdf_pop;
  exec_st_e          exec_st;

  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic              cmd_err_q, ovf_err_q;
  logic              unused_addr_bits;

  assign rst = ui_clk_sync_rst;
  assign unused_addr_bits = ^{app_addr[ADDR_W-1:MEM_AW+3], app_addr[2:0]};

  // Calibration: down-counter loaded on reset, done at terminal count.
  always_ff @(posedge ui_clk) begin
    if (rst)                  cal_cnt_q <= CW'(CALIB_CYCLES);
    else if (cal_cnt_q != '0) cal_cnt_q <= cal_cnt_q - CW'(1);
  end
  assign calib = (cal_cnt_q == '0);

`ifdef DDR4_RESP_THROTTLE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge ui_clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  // Two-bit ANDs give ~25% low time, on disjoint bits so the channels differ.
  assign thr_cmd = ~(lfsr_q[0] & lfsr_q[7]);
  assign thr_wdf = ~(lfsr_q[3] & lfsr_q[11]);
`else
  assign thr_cmd = 1'b1;
  assign thr_wdf = 1'b1;
`endif

  assign app_rdy     = calib & ~cmd_full & thr_cmd;
  assign app_wdf_rdy = calib & ~wdf_full & thr_wdf;

  assign cmd_acc   = app_en & app_rdy;
  assign cmd_legal = (app_cmd == CMD_WRITE) | (app_cmd == CMD_READ);
  assign cmd_push  = cmd_acc & cmd_legal;
  assign wdf_push  = app_wdf_wren & app_wdf_rdy;

  ddr4_app_sfifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (ui_clk),
    .rst_i   (rst),
    .push_i  (cmd_push),
    .wdata_i ({app_cmd, app_addr[MEM_AW+2:3]}),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_cnt)
  );

  ddr4_app_sfifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
    .clk_i   (ui_clk),
    .rst_i   (rst),
    .push_i  (wdf_push),
    .wdata_i ({app_wdf_data, app_wdf_mask}),
    .pop_i   (wdf_pop),
    .rdata_o (wdf_head),
    .full_o  (wdf_full),
    .empty_o (wdf_empty),
    .count_o (wdf_cnt)
  );

  assign head_cmd  = cmd_head[MEM_AW +: 3];
  assign head_idx  = cmd_head[MEM_AW-1:0];
  assign head_data = wdf_head[MASK_W +: DATA_W];
  assign head_mask = wdf_head[MASK_W-1:0];

  always_comb begin
    exec_st = ST_IDLE;
    cmd_pop = 1'b0;
    wdf_pop = 1'b0;
    if (!cmd_empty) begin
      if (head_cmd == CMD_READ) begin
        exec_st = ST_RD;
        cmd_pop = 1'b1;
      end else if (!wdf_empty) begin
        exec_st = ST_WR;
        cmd_pop = 1'b1;
        wdf_pop = 1'b1;
      end else begin
        exec_st = ST_WR_WAIT;
      end
    end
  end

  // Burst array is intentionally not reset so data survives a UI reset.
  always_ff @(posedge ui_clk) begin
    if (exec_st == ST_WR) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!head_mask[b]) mem_q[head_idx][b*8 +: 8] <= head_data[b*8 +: 8];
      end
    end
  end

  // Latency pipe: each stage only loads on a valid so app_rd_data holds.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= (exec_st == ST_RD);
      if (exec_st == ST_RD) dat_q[0] <= mem_q[head_idx];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign app_rd_data       = dat_q[RD_LAT-1];
  assign app_rd_data_valid = vld_q[RD_LAT-1];
  assign app_rd_data_end   = vld_q[RD_LAT-1];

  // rd_cnt_q counts queued reads; the FIFO holds no write when it equals
  // the FIFO occupancy.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      cmd_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_q + (CAW+1)'(cmd_push & (app_cmd == CMD_READ))
                           - (CAW+1)'(exec_st == ST_RD);
      if ((cmd_acc & ~cmd_legal) | (app_wdf_wren & ~app_wdf_end)) cmd_err_q <= 1'b1;
      if ((wdf_cnt == (WAW+1)'(WDF_DEPTH)) && (cmd_cnt == rd_cnt_q)) ovf_err_q <= 1'b1;
    end
  end

  assign init_calib_complete = calib;
  assign cmd_err             = cmd_err_q;
  assign ovf_err             = ovf_err_q;

endmodule

// File: tb/tb_ddr4_app_responder.sv
`timescale 1ns/1ps
module tb_ddr4_app_responder;
  import ddr4_app_pkg::*;

  localparam int MEM_AW    = 10;
  localparam int CMD_DEPTH = 8;
  localparam int WDF_DEPTH = 16;
  localparam int RD_LAT    = 4;
  localparam int CALIB     = 64;

  logic              ui_clk = 1'b0;
  logic              rst = 1'b1;
  logic              app_en = 1'b0;
  logic [2:0]        app_cmd = '0;
  logic [ADDR_W-1:0] app_addr = '0;
  logic              app_rdy;
  logic              app_wdf_wren = 1'b0;
  logic              app_wdf_end = 1'b0;
  logic [DATA_W-1:0] app_wdf_data = '0;
  logic [MASK_W-1:0] app_wdf_mask = '0;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid, app_rd_data_end;
  logic              init_calib_complete, cmd_err, ovf_err;

  always #5 ui_clk = ~ui_clk;

  ddr4_app_responder dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (rst),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .cmd_err             (cmd_err),
    .ovf_err             (ovf_err)
  );

  // ---------------- behavioural reference ----------------
  typedef struct { bit rd; int idx; } mcmd_t;
  typedef struct { int due; logic [DATA_W-1:0] d; } mrd_t;

  mcmd_t             cq[$];
  logic [DATA_W-1:0] wdq[$];
  logic [MASK_W-1:0] wmq[$];
  mrd_t              pq[$];
  logic [DATA_W-1:0] mmem [1 << MEM_AW];
  int                since = 0;
  int                edge_no = 0;
  bit                m_cerr, m_ovf, m_v;
  logic [DATA_W-1:0] m_last;
  bit                acc_c, acc_w;

  int n_chk = 0, n_fail = 0;
  logic [DATA_W-1:0] got_q[$];
  int                got_e[$];

  function automatic bit m_calib();
    return since >= CALIB;
  endfunction
  function automatic bit m_rdy_c();
    return m_calib() && cq.size() < CMD_DEPTH;
  endfunction
  function automatic bit m_rdy_w();
    return m_calib() && wdq.size() < WDF_DEPTH;
  endfunction

  task automatic model_step();
    int nw;
    logic [DATA_W-1:0] w;
    edge_no++;
    acc_c = 0;
    acc_w = 0;
    if (rst) begin
      cq.delete(); wdq.delete(); wmq.delete(); pq.delete();
      since = 0; m_cerr = 0; m_ovf = 0; m_v = 0; m_last = '0;
    end else begin
      nw = 0;
      foreach (cq[i]) if (!cq[i].rd) nw++;
      if (wdq.size() == WDF_DEPTH && nw == 0) m_ovf = 1;
      if (app_wdf_wren && !app_wdf_end) m_cerr = 1;
      acc_c = app_en && m_rdy_c();
      acc_w = app_wdf_wren && m_rdy_w();
      if (acc_c && app_cmd > 3'd1) m_cerr = 1;
      if (cq.size() > 0) begin
        if (cq[0].rd) begin
          pq.push_back('{edge_no + RD_LAT - 1, mmem[cq[0].idx]});
          void'(cq.pop_front());
        end else if (wdq.size() > 0) begin
          w = mmem[cq[0].idx];
          for (int b = 0; b < MASK_W; b++)
            if (!wmq[0][b]) w[b*8 +: 8] = wdq[0][b*8 +: 8];
          mmem[cq[0].idx] = w;
          void'(cq.pop_front()); void'(wdq.pop_front()); void'(wmq.pop_front());
        end
      end
      if (acc_c && app_cmd <= 3'd1)
        cq.push_back('{app_cmd == 3'd1, int'(app_addr[MEM_AW+2:3])});
      if (acc_w) begin
        wdq.push_back(app_wdf_data);
        wmq.push_back(app_wdf_mask);
      end
      if (since < CALIB) since++;
      m_v = (pq.size() > 0) && (pq[0].due == edge_no);
      if (m_v) m_last = pq.pop_front().d;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_no, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_no, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at edge %0d", nm, edge_no);
  endtask

  // One clock: model steps on the edge, DUT compared on the falling edge.
  task automatic tick();
    @(posedge ui_clk);
    model_step();
    @(negedge ui_clk);
    chk("init_calib_complete", 64'(init_calib_complete), 64'(m_calib()));
    chk("app_rdy", 64'(app_rdy), 64'(m_rdy_c()));
    chk("app_wdf_rdy", 64'(app_wdf_rdy), 64'(m_rdy_w()));
    chk("app_rd_data_valid", 64'(app_rd_data_valid), 64'(m_v));
    chk("app_rd_data_end", 64'(app_rd_data_end), 64'(m_v));
    chkd("app_rd_data", app_rd_data, m_last);
    chk("cmd_err", 64'(cmd_err), 64'(m_cerr));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    if (app_rd_data_valid) begin
      got_q.push_back(app_rd_data);
      got_e.push_back(edge_no);
    end
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a);
    bit done = 0;
    app_en = 1; app_cmd = c; app_addr = a;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      done = acc_c;
    end
    app_en = 0;
    if (!done) timeout("cmd_accept");
  endtask

  task automatic send_data(input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    bit done = 0;
    app_wdf_wren = 1; app_wdf_end = 1; app_wdf_data = d; app_wdf_mask = m;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      done = acc_w;
    end
    app_wdf_wren = 0; app_wdf_end = 0;
    if (!done) timeout("wdf_accept");
  endtask

  task automatic wr_same(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [MASK_W-1:0] m);
    int k = 0;
    app_en = 1; app_cmd = CMD_WRITE; app_addr = a;
    app_wdf_wren = 1; app_wdf_end = 1; app_wdf_data = d; app_wdf_mask = m;
    while ((app_en || app_wdf_wren) && k < 200) begin
      tick();
      if (acc_c) app_en = 0;
      if (acc_w) begin app_wdf_wren = 0; app_wdf_end = 0; end
      k++;
    end
    if (app_en || app_wdf_wren) begin
      app_en = 0; app_wdf_wren = 0; app_wdf_end = 0;
      timeout("write_accept");
    end
  endtask

  task automatic wait_rd(input int n);
    int k = 0;
    while (got_q.size() < n && k < 100) begin
      tick();
      k++;
    end
    if (got_q.size() < n) timeout("read_return");
  endtask

  task automatic wait_calib(output int rise);
    rise = -1;
    for (int k = 1; k <= CALIB + 6; k++) begin
      tick();
      if (rise < 0 && init_calib_complete) rise = k;
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr(input int idx);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    a[MEM_AW+2:3] = MEM_AW'(idx);
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, acc_e;
    logic [DATA_W-1:0] p1, p2, p3;
    logic [DATA_W-1:0] masked;
    logic [DATA_W-1:0] exp4 [8];
    logic [ADDR_W-1:0] rd_addrs [7];
    int r;

    // reset and calibration
    rst = 1;
    repeat (3) tick();
    rst = 0;
    wait_calib(rise);
    chk("calib_rise_cycle", 64'(rise), 64'd64);
    chk("no_read_valid_idle", 64'(got_q.size()), 64'd0);

    // simple write then read, latency and data
    wr_same(ADDR_W'('h8), {64{8'hA5}}, '0);
    send_cmd(CMD_READ, ADDR_W'('h8));
    acc_e = edge_no;
    wait_rd(1);
    if (got_q.size() >= 1) begin
      chk("rd_latency", 64'(got_e[0] - acc_e), 64'd4);
      chkd("rd_a5", got_q[0], {64{8'hA5}});
    end

    // byte-masked merge
    got_q.delete(); got_e.delete();
    masked = {{63{8'h11}}, 8'hFF};
    wr_same(ADDR_W'('h40), {64{8'h11}}, '0);
    wr_same(ADDR_W'('h40), {64{8'hFF}}, {{63{1'b1}}, 1'b0});
    send_cmd(CMD_READ, ADDR_W'('h40));
    wait_rd(1);
    if (got_q.size() >= 1) chkd("rd_masked", got_q[0], masked);

    // data ahead of command, stalled head, full command FIFO, in-order reads
    got_q.delete(); got_e.delete();
    p1 = rand_data();
    p2 = rand_data();
    send_data(p1, '0);
    repeat (3) tick();
    send_cmd(CMD_WRITE, ADDR_W'('h100));
    send_cmd(CMD_WRITE, ADDR_W'('h140));
    rd_addrs = '{ADDR_W'('h100), ADDR_W'('h140), ADDR_W'('h8), ADDR_W'('h40),
                 ADDR_W'('h100), ADDR_W'('h140), ADDR_W'('h8)};
    foreach (rd_addrs[i]) send_cmd(CMD_READ, rd_addrs[i]);
    chk("rdy_low_when_full", 64'(app_rdy), 64'd0);
    send_data(p2, '0);
    send_cmd(CMD_READ, ADDR_W'('h140));
    exp4 = '{p1, p2, {64{8'hA5}}, masked, p1, p2, {64{8'hA5}}, p2};
    wait_rd(8);
    if (got_q.size() >= 8)
      foreach (exp4[i]) chkd($sformatf("rd_order_%0d", i), got_q[i], exp4[i]);

    // address wrap and illegal command
    got_q.delete(); got_e.delete();
    p3 = rand_data();
    wr_same(ADDR_W'((1 << 13) + 'h10), p3, '0);
    send_cmd(CMD_READ, ADDR_W'('h10));
    wait_rd(1);
    if (got_q.size() >= 1) chkd("rd_wrap", got_q[0], p3);
    chk("cmd_err_clear", 64'(cmd_err), 64'd0);
    send_cmd(3'b111, ADDR_W'('h10));
    tick();
    chk("cmd_err_illegal", 64'(cmd_err), 64'd1);
    send_cmd(CMD_READ, ADDR_W'('h10));
    wait_rd(2);
    if (got_q.size() >= 2) chkd("illegal_no_write", got_q[1], p3);

    // reset with reads in flight
    got_q.delete(); got_e.delete();
    send_cmd(CMD_READ, ADDR_W'('h10));
    send_cmd(CMD_READ, ADDR_W'('h8));
    send_cmd(CMD_READ, ADDR_W'('h40));
    rst = 1;
    tick();
    tick();
    rst = 0;
    wait_calib(rise);
    chk("calib_rise_after_rst", 64'(rise), 64'd64);
    chk("no_valid_after_rst", 64'(got_q.size()), 64'd0);
    chk("cmd_err_cleared_by_rst", 64'(cmd_err), 64'd0);
    send_cmd(CMD_READ, ADDR_W'('h8));
    wait_rd(1);
    if (got_q.size() >= 1) chkd("mem_kept_over_rst", got_q[0], {64{8'hA5}});

    // randomized traffic over a prefilled window of 16 bursts
    for (int i = 0; i < 16; i++) wr_same(rand_addr(i), rand_data(), '0);
    for (int c = 0; c < 2000; c++) begin
      rst = (c == 1000);
      app_en = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      app_cmd = (r == 0) ? 3'($urandom_range(2, 7)) : ((r < 8) ? CMD_WRITE : CMD_READ);
      app_addr = rand_addr($urandom_range(0, 15));
      app_wdf_wren = ($urandom_range(0, 3) == 0);
      app_wdf_end = ($urandom_range(0, 63) == 0) ? 1'b0 : app_wdf_wren;
      app_wdf_data = rand_data();
      app_wdf_mask = ($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom};
      tick();
    end
    rst = 0; app_en = 0; app_wdf_wren = 0; app_wdf_end = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
